// File: rtl/rcv_word_fifo.sv
// rtl/rcv_word_fifo.sv - 32-bit word receive buffer presenting 64-bit blocks to the cipher core
module rcv_word_fifo #(
    parameter int DEPTH_WORDS = 8,
    parameter int CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             rcv_enq_word,
    input  logic [31:0]      wdata,
    input  logic             clear,
    input  logic             blk_ready,
    output logic             blk_valid,
    output logic [63:0]      blk_data,
    output logic             rcv_fifo_full,
    output logic             rcv_fifo_empty,
    output logic [CNT_W-1:0] word_count,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO   = PTR_W'(2);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow_q;

    logic push_ok;
    logic push_drop;
    logic pop;

    // Space and block availability come from registered count only, so a
    // same-cycle pop never makes room for the push beside it.
    assign push_ok   = rcv_enq_word && (count < DEPTH_CNT);
    assign push_drop = rcv_enq_word && (count == DEPTH_CNT);
    assign pop       = blk_valid && blk_ready;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_drop;
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_TWO;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_TWO;
                2'b11:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // rd_ptr is always even, so its partner slot is rd_ptr with bit 0 set.
    assign blk_valid      = (count >= CNT_TWO);
    assign blk_data       = {mem[rd_ptr], mem[rd_ptr | PTR_ONE]};
    assign rcv_fifo_full  = (count == DEPTH_CNT);
    assign rcv_fifo_empty = (count == '0);
    assign word_count     = count;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_rcv_word_fifo.sv
// tb/tb_rcv_word_fifo.sv - directed self-checking bench for rcv_word_fifo
module tb_rcv_word_fifo;

    logic        HCLK;
    logic        HRESETn;
    logic        rcv_enq_word;
    logic [31:0] wdata;
    logic        clear;
    logic        blk_ready;
    logic        blk_valid;
    logic [63:0] blk_data;
    logic        rcv_fifo_full;
    logic        rcv_fifo_empty;
    logic [3:0]  word_count;
    logic        overflow;

    int checks;
    int failures;

    rcv_word_fifo #(.DEPTH_WORDS(8)) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .rcv_enq_word   (rcv_enq_word),
        .wdata          (wdata),
        .clear          (clear),
        .blk_ready      (blk_ready),
        .blk_valid      (blk_valid),
        .blk_data       (blk_data),
        .rcv_fifo_full  (rcv_fifo_full),
        .rcv_fifo_empty (rcv_fifo_empty),
        .word_count     (word_count),
        .overflow       (overflow)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        rcv_enq_word = 1'b1;
        wdata        = w;
        step();
        rcv_enq_word = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        checks++;
        if ({blk_valid, rcv_fifo_empty, rcv_fifo_full, word_count, overflow} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_flags got valid=%0b empty=%0b full=%0b cnt=%0d ovf=%0b want 0 1 0 0 0",
                     blk_valid, rcv_fifo_empty, rcv_fifo_full, word_count, overflow);
        end
        checks++;
        if (blk_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_data got %h want 0", blk_data);
        end
        HRESETn = 1'b1;
        step();
    endtask

    task automatic test_push_pair();
        push(32'h1111_1111);
        checks++;
        if ({word_count, blk_valid, rcv_fifo_empty} !== {4'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL push1 got cnt=%0d valid=%0b empty=%0b want 1 0 0", word_count, blk_valid, rcv_fifo_empty);
        end
        push(32'h2222_2222);
        checks++;
        if (blk_valid !== 1'b1 || blk_data !== 64'h1111_1111_2222_2222) begin
            failures++;
            $display("FAIL push2 got valid=%0b data=%h want 1 1111111122222222", blk_valid, blk_data);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] w [8];
        for (int i = 0; i < 8; i++) w[i] = 32'h1111_1111 * 32'(i + 1);
        for (int i = 2; i < 8; i++) push(w[i]);
        checks++;
        if (rcv_fifo_full !== 1'b1 || word_count !== 4'd8) begin
            failures++;
            $display("FAIL fill got full=%0b cnt=%0d want 1 8", rcv_fifo_full, word_count);
        end
        push(32'hDEAD_BEEF);
        checks++;
        if (overflow !== 1'b1 || word_count !== 4'd8) begin
            failures++;
            $display("FAIL ovf_pulse got ovf=%0b cnt=%0d want 1 8", overflow, word_count);
        end
        step();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_one_cycle got %0b want 0", overflow);
        end
        blk_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (blk_valid !== 1'b1 || blk_data !== {w[2*b], w[2*b+1]}) begin
                failures++;
                $display("FAIL drain%0d got valid=%0b data=%h want 1 %h", b, blk_valid, blk_data, {w[2*b], w[2*b+1]});
            end
            step();
        end
        blk_ready = 1'b0;
        checks++;
        if (rcv_fifo_empty !== 1'b1 || blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got empty=%0b valid=%0b want 1 0", rcv_fifo_empty, blk_valid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] q [$];
        int blocks;
        int pushed;
        logic exp_valid;
        blocks    = 0;
        pushed    = 0;
        blk_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (pushed == 20 && q.size() < 2) break;
            exp_valid    = (q.size() >= 2);
            rcv_enq_word = (pushed < 20);
            wdata        = 32'hA000_0000 + 32'(pushed);
            checks++;
            if (blk_valid !== exp_valid || overflow !== 1'b0) begin
                failures++;
                $display("FAIL wrap_valid cyc%0d got valid=%0b ovf=%0b want %0b 0", cyc, blk_valid, overflow, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (blk_data !== {q[0], q[1]}) begin
                    failures++;
                    $display("FAIL wrap_data blk%0d got %h want %h", blocks, blk_data, {q[0], q[1]});
                end
            end
            step();
            if (exp_valid) begin
                void'(q.pop_front());
                void'(q.pop_front());
                blocks++;
            end
            if (rcv_enq_word) begin
                q.push_back(wdata);
                pushed++;
            end
        end
        rcv_enq_word = 1'b0;
        blk_ready    = 1'b0;
        checks++;
        if (blocks != 10 || rcv_fifo_empty !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end got blocks=%0d empty=%0b ovf=%0b want 10 1 0", blocks, rcv_fifo_empty, overflow);
        end
    endtask

    task automatic test_push_pop_at3();
        push(32'hC000_0001);
        push(32'hC000_0002);
        push(32'hC000_0003);
        checks++;
        if (word_count !== 4'd3 || blk_data !== 64'hC000_0001_C000_0002) begin
            failures++;
            $display("FAIL pp3_pre got cnt=%0d data=%h want 3 c0000001c0000002", word_count, blk_data);
        end
        blk_ready = 1'b1;
        push(32'hC000_0004);
        blk_ready = 1'b0;
        checks++;
        if (word_count !== 4'd2 || blk_valid !== 1'b1 || blk_data !== 64'hC000_0003_C000_0004) begin
            failures++;
            $display("FAIL pp3_post got cnt=%0d valid=%0b data=%h want 2 1 c0000003c0000004", word_count, blk_valid, blk_data);
        end
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
        checks++;
        if (word_count !== 4'd0) begin
            failures++;
            $display("FAIL pp3_drain got cnt=%0d want 0", word_count);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 8; i++) push(32'hE000_0000 + 32'(i));
        blk_ready = 1'b1;
        push(32'hF000_0000);
        checks++;
        if (overflow !== 1'b1 || word_count !== 4'd6 || blk_data !== 64'hE000_0003_E000_0004) begin
            failures++;
            $display("FAIL fullpp got ovf=%0b cnt=%0d data=%h want 1 6 e0000003e0000004", overflow, word_count, blk_data);
        end
        step();
        step();
        checks++;
        if (blk_data !== 64'hE000_0007_E000_0008 || word_count !== 4'd2) begin
            failures++;
            $display("FAIL fullpp_tail got data=%h cnt=%0d want e0000007e0000008 2", blk_data, word_count);
        end
        step();
        blk_ready = 1'b0;
        checks++;
        if (rcv_fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL fullpp_empty got %0b want 1", rcv_fifo_empty);
        end
    endtask

    task automatic test_clear();
        for (int i = 1; i <= 5; i++) push(32'hB000_0000 + 32'(i));
        clear = 1'b1;
        push(32'hB000_0006);
        clear = 1'b0;
        checks++;
        if ({word_count, rcv_fifo_empty, blk_valid, overflow} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clear5 got cnt=%0d empty=%0b valid=%0b ovf=%0b want 0 1 0 0",
                     word_count, rcv_fifo_empty, blk_valid, overflow);
        end
        for (int i = 1; i <= 8; i++) push(32'hB100_0000 + 32'(i));
        clear = 1'b1;
        push(32'hB100_0009);
        clear = 1'b0;
        checks++;
        if (overflow !== 1'b0 || word_count !== 4'd0) begin
            failures++;
            $display("FAIL clear_full got ovf=%0b cnt=%0d want 0 0", overflow, word_count);
        end
    endtask

    task automatic test_async_reset();
        push(32'h5555_0001);
        push(32'h5555_0002);
        push(32'h5555_0003);
        #2;
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({blk_valid, rcv_fifo_empty, rcv_fifo_full, word_count, overflow} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0}
            || blk_data !== 64'd0) begin
            failures++;
            $display("FAIL async_reset got valid=%0b empty=%0b full=%0b cnt=%0d ovf=%0b data=%h want 0 1 0 0 0 0",
                     blk_valid, rcv_fifo_empty, rcv_fifo_full, word_count, overflow, blk_data);
        end
        #3;
        HRESETn = 1'b1;
        step();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        HRESETn      = 1'b0;
        rcv_enq_word = 1'b0;
        wdata        = '0;
        clear        = 1'b0;
        blk_ready    = 1'b0;
        test_reset();
        test_push_pair();
        test_fill_overflow();
        test_wrap();
        test_push_pop_at3();
        test_full_push_pop();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rcv_word_fifo.md
# rcv_word_fifo

Receive-side buffer between the AHB slave interface and the cipher core. It accepts 32-bit words pushed by the slave on `rcv_enq_word` and reports `rcv_fifo_full` and `rcv_fifo_empty` back to the slave's register logic. Downstream, it presents buffered words to the cipher core as 64-bit blocks over a valid/ready handshake. It also supports a synchronous flush and flags dropped writes.

## Interface
- `DEPTH_WORDS`, default 8: storage depth in 32-bit words; even, power of 2, ≥4.
- `CNT_W`, default $clog2(DEPTH_WORDS)+1: width of `word_count`; derived, not overridden.

Ports:
- `HCLK`  in  1  clock; all state updates on rising edge.
- `HRESETn`  in  1  reset, asynchronous, active-low.
- `rcv_enq_word`  in  1  push request from the AHB slave, one word per cycle.
- `wdata`  in  32  word to push; sampled with `rcv_enq_word`.
- `clear`  in  1  synchronous flush.
- `blk_ready`  in  1  cipher core accepts the presented block.
- `blk_valid`  out  1  at least two words are buffered; a block is presented.
- `blk_data`  out  64  block; `{oldest word, second-oldest word}`.
- `rcv_fifo_full`  out  1  `word_count == DEPTH_WORDS`.
- `rcv_fifo_empty`  out  1  `word_count == 0`.
- `word_count`  out  CNT_W  words currently stored.
- `overflow`  out  1  one-cycle pulse when a push is dropped.

## Operation
- Storage is a circular buffer of DEPTH_WORDS × 32-bit registers.
  - Registered state: `wr_ptr` and `rd_ptr` (log2(DEPTH_WORDS) bits each, wrap modulo DEPTH_WORDS), `count` (CNT_W bits).
- Push accepted iff `rcv_enq_word && count < DEPTH_WORDS` (registered count, same cycle).
  - On accept: `mem[wr_ptr] <= wdata`, then `wr_ptr` increments.
  - A pop in the same cycle does not free space for that cycle's push.
- Push while full: the word is dropped and `overflow` is asserted for the following cycle. Pointers, count and memory are unchanged.
- Pop (block transfer) occurs iff `blk_valid && blk_ready`: `rd_ptr += 2` (mod DEPTH_WORDS) and `count -= 2`.
- `blk_valid = (count >= 2)`. `blk_data = {mem[rd_ptr], mem[rd_ptr+1]}`.
  - `rd_ptr` is always even, so a block never straddles the wrap.
- Count update per cycle:
  - push only: +1
  - pop only: −2
  - push and pop together: −1
  - neither: 0
- An odd residual word keeps `blk_valid` low and `rcv_fifo_empty` low until the next push completes a pair.
- `clear` has priority over push and pop in the same cycle:
  - `wr_ptr`, `rd_ptr` and `count` go to 0.
  - Memory contents are retained but unreachable.
  - `overflow` is not asserted, even if a push to a full FIFO coincides with `clear`.
- `blk_ready` while `blk_valid` is low has no effect.

## Timing
- Reset (async assert, sync release) gives:
  - `wr_ptr = rd_ptr = count = 0`; all memory words 0.
  - `blk_valid = 0`, `blk_data = 0`, `rcv_fifo_empty = 1`, `rcv_fifo_full = 0`, `word_count = 0`, `overflow = 0`.
- Reset mid-operation discards all buffered words immediately; there is no partial block output.
- `rcv_fifo_full`, `rcv_fifo_empty`, `blk_valid`, `blk_data` and `word_count` are decoded from registered state only. There is no combinational path from any input to any output.
- Push latency: a push sampled at edge k is reflected in `word_count` and flags after edge k. The second word of a pair sampled at edge k raises `blk_valid` after edge k.
- Pop: a handshake at edge k advances `blk_data` to the next pair after edge k. `blk_valid` stays high for back-to-back transfers while `count >= 2`.
- Throughput: 1 word/cycle in; 1 block per 2 cycles sustained out. 1 block/cycle out is possible while draining.
- `overflow` is a registered pulse, high for exactly one cycle per dropped push.

## Test plan
- Reset, then push 0x11111111 and 0x22222222 with `blk_ready=0`:
  - after push 1: `word_count=1`, `blk_valid=0`, `empty=0`
  - after push 2: `blk_valid=1`, `blk_data=0x11111111_22222222`
- Fill to 8 words, then push 0xDEADBEEF:
  - `full=1`, `overflow` pulses one cycle, `word_count` stays 8.
  - Drain four blocks: all match the original order, with no 0xDEADBEEF.
- Wrap-around with DEPTH_WORDS=8 and the cipher core continuously ready:
  - Stream 20 words: 10 blocks out in order; pointers wrap twice; `overflow` never asserts.
- Simultaneous push and pop at `count=3`:
  - next `count=2`, `blk_data` = words 3 and 4, new word stored at the correct slot.
- Full FIFO, pop and push in the same cycle:
  - the push is dropped (`overflow=1`); `count=6` next cycle.
- `clear` asserted together with a push at `count=5`:
  - next cycle `count=0`, `empty=1`, `blk_valid=0`, `overflow=0`.
  - Then assert `HRESETn` low mid-stream: all outputs return to reset values asynchronously.
